rowbias_shuffler: RTL and testbench

ROWBIAS_SHUFFLER -- requirements
Module: rowbias_shuffler

---
 rtl/rowbias_pkg.sv | 28 ++
 rtl/rowbias_shuffler_lfsr16.sv | 37 +++
 rtl/rowbias_shuffler.sv | 146 ++++++++++++++
 tb/tb_rowbias_shuffler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rowbias_pkg.sv
// ============================================================================
// Module : rowbias_pkg
// Brief  : Shared FSM encoding and LFSR constants for the row-bias shuffler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef GRID_LEN
`define GRID_LEN 9
`endif

package rowbias_pkg;

    localparam int              LFSR_W         = 16;
    localparam logic [15:0]     LFSR_TAPS      = 16'hB400;
    localparam logic [15:0]     LFSR_SAFE_SEED = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHUFFLE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rowbias_shuffler_lfsr16.sv
// ============================================================================
// Module : lfsr16
// Brief  : 16-bit right-shifting Galois LFSR with a zero-seed lock-up guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr16
    import rowbias_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VALUE = 16'hACE1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= RESET_VALUE;
        end else if (load) begin
            // an all-zero state would never leave zero
            r_value <= (load_value == '0) ? LFSR_SAFE_SEED : load_value;
        end else begin
            r_value <= {1'b0, r_value[LFSR_W-1:1]} ^ (r_value[0] ? LFSR_TAPS : '0);
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/rowbias_shuffler.sv
// ============================================================================
// Module : rowbias_shuffler
// Brief  : Builds a permutation of W one-hot values (Fisher-Yates with LFSR
//          rejection sampling) and streams it out as W pool writes.
//          Shuffling is compiled in only when ROWBIAS_SHUFFLE_EN is defined;
//          otherwise the identity permutation is emitted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rowbias_shuffler
    import rowbias_pkg::*;
#(
    parameter int                W    = `GRID_LEN,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
    localparam int               AW   = (W > 1) ? $clog2(W) : 1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pool_valid,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [W-1:0]      wr_data
);

`ifdef ROWBIAS_SHUFFLE_EN
    localparam bit c_shuffle = (W > 1);
`else
    localparam bit c_shuffle = 1'b0;
`endif
    localparam logic [AW-1:0] c_last = AW'(W - 1);

    state_t            r_state;
    logic [W-1:0]      r_perm [W];
    logic [AW-1:0]     r_i;
    logic [AW-1:0]     r_wr_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_pool_valid;
    logic              r_wr_en;

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_lfsr_load;
    logic [AW-1:0]     w_j;
    logic              w_unused_lfsr;

    assign w_lfsr_load = seed_load && (r_state == ST_IDLE);

    lfsr16 #(
        .RESET_VALUE (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (w_lfsr_load),
        .load_value (seed),
        .value      (w_lfsr)
    );

    assign w_j           = w_lfsr[AW-1:0];
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:AW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_i          <= '0;
            r_wr_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pool_valid <= 1'b0;
            r_wr_en      <= 1'b0;
            for (int k = 0; k < W; k++) begin
                r_perm[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_INIT;
                        r_busy       <= 1'b1;
                        r_pool_valid <= 1'b0;
                    end
                end
                ST_INIT: begin
                    for (int k = 0; k < W; k++) begin
                        r_perm[k] <= W'(1) << k;
                    end
                    r_i <= c_last;
                    if (c_shuffle) begin
                        r_state <= ST_SHUFFLE;
                    end else begin
                        r_state   <= ST_EMIT;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                    end
                end
                ST_SHUFFLE: begin
                    // out-of-range candidates are simply retried next cycle
                    if (w_j <= r_i) begin
                        r_perm[r_i] <= r_perm[w_j];
                        r_perm[w_j] <= r_perm[r_i];
                        r_i         <= r_i - 1'b1;
                        if (r_i == AW'(1)) begin
                            r_state   <= ST_EMIT;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= '0;
                        end
                    end
                end
                ST_EMIT: begin
                    if (r_wr_addr == c_last) begin
                        r_state      <= ST_DONE;
                        r_wr_en      <= 1'b0;
                        r_wr_addr    <= '0;
                        r_done       <= 1'b1;
                        r_pool_valid <= 1'b1;
                    end else begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pool_valid = r_pool_valid;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_en ? r_perm[r_wr_addr] : '0;

endmodule

`default_nettype wire

// File: tb/tb_rowbias_shuffler.sv
// ============================================================================
// Module : tb_rowbias_shuffler
// Brief  : Directed bench for rowbias_shuffler (W=9, W=4, W=1 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rowbias_shuffler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // W=9 instance
    logic        rst_n9, start9, sl9;
    logic [15:0] seed9;
    logic        busy9, done9, pool_valid9, wr_en9;
    logic [3:0]  wr_addr9;
    logic [8:0]  wr_data9;

    // W=4 and W=1 instances
    logic        rst_s, start4, start1;
    logic        busy4, done4, pool_valid4, wr_en4;
    logic [1:0]  wr_addr4;
    logic [3:0]  wr_data4;
    logic        busy1, done1, pool_valid1, wr_en1;
    logic [0:0]  wr_addr1;
    logic [0:0]  wr_data1;

    rowbias_shuffler #(.W(9)) dut9 (
        .clock(clk), .reset(rst_n9), .start(start9), .seed_load(sl9), .seed(seed9),
        .busy(busy9), .done(done9), .pool_valid(pool_valid9), .wr_en(wr_en9),
        .wr_addr(wr_addr9), .wr_data(wr_data9)
    );

    rowbias_shuffler #(.W(4)) dut4 (
        .clock(clk), .reset(rst_s), .start(start4), .seed_load(1'b0), .seed(16'h0000),
        .busy(busy4), .done(done4), .pool_valid(pool_valid4), .wr_en(wr_en4),
        .wr_addr(wr_addr4), .wr_data(wr_data4)
    );

    rowbias_shuffler #(.W(1)) dut1 (
        .clock(clk), .reset(rst_s), .start(start1), .seed_load(1'b0), .seed(16'h0000),
        .busy(busy1), .done(done1), .pool_valid(pool_valid1), .wr_en(wr_en1),
        .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference LFSR for the W=9 instance
    logic [15:0] m_lfsr;
    bit          m_idle = 1'b1;
    logic [8:0]  m_perm [9];

    always @(posedge clk or negedge rst_n9) begin
        if (!rst_n9)              m_lfsr <= 16'hACE1;
        else if (sl9 && m_idle)   m_lfsr <= (seed9 == 16'h0000) ? 16'h0001 : seed9;
        else                      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic run9(input bit poke, input int abort_at);
        logic [8:0] seen;
        bit         ok;
        int         mi;
`ifdef ROWBIAS_SHUFFLE_EN
        logic [3:0] j;
        logic [8:0] tmp;
        bit         last;
`endif
        start9 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start9 = 1'b0;
        sl9    = 1'b0;
        m_idle = 1'b0;
        check("init", {busy9, pool_valid9, wr_en9}, 3'b100);
        for (int k = 0; k < 9; k++) m_perm[k] = 9'(1) << k;
        mi   = 8;
        seen = '0;
        ok   = 1'b1;
        @(negedge clk);
`ifdef ROWBIAS_SHUFFLE_EN
        last = 1'b0;
        for (int t = 0; t < 4000 && !last; t++) begin
            check("shuffle", {busy9, wr_en9}, 2'b10);
            j = m_lfsr[3:0];
            if (int'(j) <= mi) begin
                tmp        = m_perm[mi];
                m_perm[mi] = m_perm[j];
                m_perm[j]  = tmp;
                last       = (mi == 1);
                mi--;
            end
            @(negedge clk);
        end
        if (!last) check("shuffle_bound", 32'd0, 32'd1);
`endif
        for (int k = 0; k < 9; k++) begin
            check("emit", {wr_en9, wr_addr9, wr_data9}, {1'b1, 4'(k), m_perm[k]});
            if ($countones(wr_data9) != 1 || (wr_data9 & seen) != '0) ok = 1'b0;
            seen |= wr_data9;
            if (k == abort_at) begin
                rst_n9 = 1'b0;
                #1;
                check("abort", {busy9, done9, pool_valid9, wr_en9, wr_addr9, wr_data9}, 32'd0);
                repeat (2) @(negedge clk);
                rst_n9 = 1'b1;
                m_idle = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("post_abort", {busy9, done9, pool_valid9, wr_en9}, 4'b0000);
                end
                check("abort_lfsr", dut9.u_lfsr.value, m_lfsr);
                return;
            end
            if (poke && k == 1) begin
                start9 = 1'b1;
                sl9    = 1'b1;
                seed9  = 16'hFFFF;
            end
            @(negedge clk);
            start9 = 1'b0;
            sl9    = 1'b0;
        end
        check("done", {done9, pool_valid9, busy9, wr_en9}, 4'b1110);
        check("perm", {ok, seen}, {1'b1, 9'h1FF});
        @(negedge clk);
        m_idle = 1'b1;
        check("idle", {busy9, done9, pool_valid9}, 3'b001);
        check("lfsr", dut9.u_lfsr.value, m_lfsr);
    endtask

    logic [6:0] exp4 [4] = '{7'b1_00_0001, 7'b1_01_0010, 7'b1_10_0100, 7'b1_11_1000};

    initial begin
        rst_n9 = 1'b0; rst_s = 1'b0;
        start9 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        sl9 = 1'b0; seed9 = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_out9", {busy9, done9, pool_valid9, wr_en9, wr_addr9, wr_data9}, 32'd0);
        check("rst_lfsr", dut9.u_lfsr.value, 16'hACE1);
        check("rst_out4", {busy4, done4, pool_valid4, wr_en4, wr_addr4, wr_data4}, 32'd0);
        check("rst_out1", {busy1, done1, pool_valid1, wr_en1, wr_addr1, wr_data1}, 32'd0);
        rst_n9 = 1'b1; rst_s = 1'b1;
        @(negedge clk);
        check("lfsr_run", dut9.u_lfsr.value, m_lfsr);
        check("no_autostart", {busy9, busy4, busy1}, 3'b000);

        // zero seed is replaced by the safe seed, then shifts to the taps value
        seed9 = 16'h0000; sl9 = 1'b1;
        @(negedge clk);
        sl9 = 1'b0;
        check("seed0", dut9.u_lfsr.value, 16'h0001);
        @(negedge clk);
        check("seed0_shift", dut9.u_lfsr.value, 16'hB400);

        // W=4 and W=1 latency
        start4 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        check("w4_init", {busy4, wr_en4}, 2'b10);
        check("w1_init", {busy1, wr_en1, pool_valid1}, 3'b100);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
`ifndef ROWBIAS_SHUFFLE_EN
            check("w4_emit", {wr_en4, wr_addr4, wr_data4}, exp4[k]);
`endif
            if (k == 0) check("w1_emit", {wr_en1, wr_addr1, wr_data1}, 3'b101);
            if (k == 1) check("w1_done", {done1, pool_valid1, busy1, wr_en1}, 4'b1110);
            if (k == 2) check("w1_idle", {busy1, done1, pool_valid1}, 3'b001);
            @(negedge clk);
        end
`ifndef ROWBIAS_SHUFFLE_EN
        check("w4_done", {done4, pool_valid4, busy4, wr_en4}, 4'b1110);
`endif

        // seed load coincident with the first start
        seed9 = 16'h1234; sl9 = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            run9(r == 5, (r == 10) ? 2 : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
